// File: rtl/mandelbrot_pkg.sv
// Shared definitions for the Mandelbrot pipeline.
// Holds the fixed-point format (signed 32-bit, FRAC fractional bits), the
// dispatcher state encoding, and a few handy fixed-point constants.
package mandelbrot_pkg;

  localparam int unsigned FIX_W = 32;
  localparam int unsigned FRAC  = 28;

  typedef logic signed [FIX_W-1:0] fix_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam fix_t FIX_ONE     = fix_t'(32'sd1 <<< FRAC);
  localparam fix_t FIX_TWO     = fix_t'(32'sd2 <<< FRAC);
  localparam fix_t FIX_NEG_ONE = fix_t'(-(32'sd1 <<< FRAC));
  localparam fix_t FIX_NEG_TWO = fix_t'(-(32'sd2 <<< FRAC));

endpackage

// File: rtl/pixel_dispatcher.sv
// Converts the pixel counter's raster position into a fixed-point complex
// coordinate and offers it to the iteration core over valid/ready.
// Ports:
//   clock, reset_n            - clock, async active-low reset
//   frame_start               - render request, honoured in IDLE only
//   re_min, im_max, step      - view window, latched at frame_start
//   row, col, idx             - current position from the pixel counter
//   increment                 - counter advance (px_valid & px_ready)
//   px_valid/px_ready         - pixel handshake to the core
//   px_re, px_im              - coordinate of the offered pixel
//   px_idx                    - framebuffer index (pass-through of idx)
//   busy                      - not in IDLE
//   frame_done                - one-cycle pulse after the last pixel
module pixel_dispatcher
  import mandelbrot_pkg::*;
#(
  parameter int unsigned MAXROW = 300,
  parameter int unsigned MAXCOL = 400,
  parameter int unsigned FRAC   = mandelbrot_pkg::FRAC
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        frame_start,
  input  fix_t        re_min,
  input  fix_t        im_max,
  input  fix_t        step,
  input  logic [31:0] row,
  input  logic [31:0] col,
  input  logic [31:0] idx,
  output logic        increment,
  output logic        px_valid,
  input  logic        px_ready,
  output fix_t        px_re,
  output fix_t        px_im,
  output logic [31:0] px_idx,
  output logic        busy,
  output logic        frame_done
);

  state_t state;
  state_t state_next;

  fix_t re0;
  fix_t im0;
  fix_t stp;
  fix_t re_acc;
  fix_t im_acc;

  logic col_last;
  logic row_last;

  assign col_last = (col == 32'(MAXCOL - 1));
  assign row_last = (row == 32'(MAXROW - 1));

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (frame_start) state_next = RUN;
      RUN:  if (px_ready && col_last && row_last) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from the state register
  always_comb begin
    px_valid   = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state)
      RUN: begin
        px_valid = 1'b1;
        busy     = 1'b1;
      end
      DONE: begin
        busy       = 1'b1;
        frame_done = 1'b1;
      end
      default: ;
    endcase
    increment = px_valid & px_ready;
  end

  // Window latch and coordinate accumulators; stepping on the same edge as
  // increment keeps px_re/px_im aligned with the counter's row/col.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      re0    <= '0;
      im0    <= '0;
      stp    <= '0;
      re_acc <= '0;
      im_acc <= '0;
    end else if (state == IDLE && frame_start) begin
      re0    <= re_min;
      im0    <= im_max;
      stp    <= step;
      re_acc <= re_min;
      im_acc <= im_max;
    end else if (increment) begin
      if (!col_last) begin
        re_acc <= re_acc + stp;
      end else if (!row_last) begin
        re_acc <= re0;
        im_acc <= im_acc - stp;
      end
    end
  end

  assign px_re  = re_acc;
  assign px_im  = im_acc;
  assign px_idx = idx;

  // im0 is kept for the row origin but only the running im_acc is needed.
  logic unused_ok;
  assign unused_ok = ^{im0, 32'(FRAC)};

endmodule
